// File: rtl/timed_reg_writer.sv
// ============================================================================
// Module   : timed_reg_writer
// Brief    : Replays queued (timestamp, address, data) entries as one-cycle
//            register write strobes when the running tick counter reaches them.
// Revision : 1.0
// ============================================================================
`default_nettype none

module timed_reg_writer #(
    parameter int DEPTH = 8,
    parameter int AW    = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     enable_i,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [31:0]              push_ts_i,
    input  logic [AW-1:0]            push_addr_i,
    input  logic [31:0]              push_data_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [31:0]              timestamp_o,
    output logic                     wr_stb_o,
    output logic [AW-1:0]            wr_addr_o,
    output logic [31:0]              wr_data_o,
    output logic                     late_o,
    output logic                     overflow_o
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_LW = c_PW + 1;

    logic [31:0]     r_mem_ts   [DEPTH];
    logic [AW-1:0]   r_mem_addr [DEPTH];
    logic [31:0]     r_mem_data [DEPTH];

    logic [c_PW-1:0] r_rd_ptr;
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_LW-1:0] r_level;
    logic            r_full;
    logic            r_empty;
    logic [31:0]     r_ts;
    logic            r_stb;
    logic [AW-1:0]   r_addr;
    logic [31:0]     r_data;
    logic            r_late;
    logic            r_ovf;

    logic [31:0]     w_head_ts;
    logic            w_issue;
    logic            w_push_ok;
    logic [c_LW-1:0] w_level_nxt;

    assign w_head_ts = r_mem_ts[r_rd_ptr];
    // Clear wins over issue so the strobe is guaranteed low after a flush.
    assign w_issue   = enable_i && !r_empty && !clear_i && (w_head_ts <= r_ts);
    assign w_push_ok = push_i && !r_full && !clear_i;

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push_ok, w_issue})
            2'b10:   w_level_nxt = r_level + c_LW'(1);
            2'b01:   w_level_nxt = r_level - c_LW'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    // Storage has no reset: validity is tracked entirely by the pointers.
    always_ff @(posedge clk_i) begin
        if (w_push_ok && !reset_i) begin
            r_mem_ts[r_wr_ptr]   <= push_ts_i;
            r_mem_addr[r_wr_ptr] <= push_addr_i;
            r_mem_data[r_wr_ptr] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_ts     <= '0;
            r_stb    <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_late   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_ts <= enable_i ? r_ts + 32'd1 : 32'd0;

            if (clear_i) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_level  <= '0;
                r_full   <= 1'b0;
                r_empty  <= 1'b1;
                r_stb    <= 1'b0;
                r_late   <= 1'b0;
                r_ovf    <= 1'b0;
            end else begin
                r_stb <= w_issue;
                if (w_issue) begin
                    r_addr   <= r_mem_addr[r_rd_ptr];
                    r_data   <= r_mem_data[r_rd_ptr];
                    r_rd_ptr <= r_rd_ptr + c_PW'(1);
                    if (w_head_ts < r_ts)
                        r_late <= 1'b1;
                end
                if (w_push_ok)
                    r_wr_ptr <= r_wr_ptr + c_PW'(1);
                else if (push_i)
                    r_ovf <= 1'b1;
                r_level <= w_level_nxt;
                r_empty <= (w_level_nxt == '0);
                r_full  <= (w_level_nxt == c_LW'(DEPTH));
            end
        end
    end

    assign full_o      = r_full;
    assign empty_o     = r_empty;
    assign level_o     = r_level;
    assign timestamp_o = r_ts;
    assign wr_stb_o    = r_stb;
    assign wr_addr_o   = r_addr;
    assign wr_data_o   = r_data;
    assign late_o      = r_late;
    assign overflow_o  = r_ovf;

endmodule

`default_nettype wire
